// File: rtl/up_mem_arb.sv
// up_mem_arb: two-requester arbiter for the up_core single-port data memory.
// One access per cycle, bounded round-robin fairness, lock for atomic RMW,
// read data returned one cycle after the grant.
module up_mem_arb #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_0,
    input  logic          lock_0,
    input  logic          we_0,
    input  logic [AW-1:0] addr_0,
    input  logic [DW-1:0] wdata_0,
    output logic          gnt_0,
    output logic          rvalid_0,
    output logic [DW-1:0] rdata_0,
    input  logic          req_1,
    input  logic          lock_1,
    input  logic          we_1,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_1,
    output logic          gnt_1,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata_1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    logic          owner;
    logic [3:0]    hold_cnt;
    logic          locked_q;
    logic          rvalid_0_q;
    logic          rvalid_1_q;
    logic [DW-1:0] rdata_0_q;
    logic [DW-1:0] rdata_1_q;

    logic          grant_valid;
    logic          grant_id;
    logic          grant_lock;
    logic          owner_req;

    // Grant selection: lock pins the owner, otherwise fairness by hold count.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        owner_req   = owner ? req_1 : req_0;
        if (rst) begin
            grant_valid = 1'b0;
        end else if (locked_q) begin
            grant_valid = owner_req;
            grant_id    = owner;
        end else if (req_0 && req_1) begin
            grant_valid = 1'b1;
            grant_id    = (hold_cnt < HOLD_LIMIT) ? owner : ~owner;
        end else if (req_0 || req_1) begin
            grant_valid = 1'b1;
            grant_id    = req_1 && !req_0;
        end
        grant_lock = grant_id ? lock_1 : lock_0;
        gnt_0      = grant_valid && !grant_id;
        gnt_1      = grant_valid && grant_id;
    end

    // Memory port mux from the granted requester; idle port drives zeros.
    always_comb begin
        mem_en    = gnt_0 | gnt_1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_0) begin
            mem_we    = we_0;
            mem_addr  = addr_0;
            mem_wdata = wdata_0;
        end else if (gnt_1) begin
            mem_we    = we_1;
            mem_addr  = addr_1;
            mem_wdata = wdata_1;
        end
    end

    // Ownership, fairness counter, lock and read-return state.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            hold_cnt   <= '0;
            locked_q   <= 1'b0;
            rvalid_0_q <= 1'b0;
            rvalid_1_q <= 1'b0;
            rdata_0_q  <= '0;
            rdata_1_q  <= '0;
        end else begin
            rvalid_0_q <= gnt_0 && !we_0;
            rvalid_1_q <= gnt_1 && !we_1;
            if (rvalid_0_q) rdata_0_q <= mem_rdata;
            if (rvalid_1_q) rdata_1_q <= mem_rdata;
            if (grant_valid) begin
                locked_q <= grant_lock;
                if (grant_id == owner) begin
                    if (hold_cnt != '1) hold_cnt <= hold_cnt + 4'd1;
                end else begin
                    owner    <= grant_id;
                    hold_cnt <= 4'd1;
                end
            end else if (locked_q && !owner_req) begin
                locked_q <= 1'b0;
            end
        end
    end

    // Read data passes straight through on the return cycle, then holds;
    // everything is forced low while reset is asserted.
    always_comb begin
        locked   = locked_q && !rst;
        rvalid_0 = rvalid_0_q && !rst;
        rvalid_1 = rvalid_1_q && !rst;
        rdata_0  = rst ? '0 : (rvalid_0_q ? mem_rdata : rdata_0_q);
        rdata_1  = rst ? '0 : (rvalid_1_q ? mem_rdata : rdata_1_q);
    end

endmodule

// File: doc/up_mem_arb.md
Name: up_mem_arb

Overview:
- Two-requester arbiter for the up_core's single-port 256x8 data memory.
- Requester 0 is the core's fetch/load/store port; requester 1 is a loader/debug/DMA port.
- Grants one access per cycle, drives the memory port, and returns read data one cycle later.
- Provides bounded round-robin fairness plus a lock for atomic read-modify-write sequences.

Parameters:
AW, 8, address width (256-entry memory)
DW, 8, data width
MAX_HOLD, 4, max consecutive unlocked grants to one requester while the other is requesting (legal range 1..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_0  input  1  requester 0 access request
lock_0  input  1  requester 0 lock request, sampled with req_0
we_0  input  1  requester 0 write enable (1=write, 0=read)
addr_0  input  AW  requester 0 address
wdata_0  input  DW  requester 0 write data
gnt_0  output  1  requester 0 access issued this cycle
rvalid_0  output  1  requester 0 read data valid
rdata_0  output  DW  requester 0 read data
req_1, lock_1, we_1, addr_1, wdata_1, gnt_1, rvalid_1, rdata_1  same as requester 0, for requester 1
mem_en  output  1  memory access strobe
mem_we  output  1  memory write strobe
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0
locked  output  1  arbiter held by current owner

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous, active-high; all state changes on the rising edge of clk.
  - Reset values: owner=0, hold_cnt=0, locked=0, rvalid_0=rvalid_1=0, rdata_0=rdata_1=0.
  - All outputs derived from state are 0 during reset.
- Request handshake:
  - Requester raises req_i with we_i/addr_i/wdata_i/lock_i stable, and holds them until it sees gnt_i=1 in the same cycle.
  - The access is issued in that cycle.
  - A requester may keep req_i high to issue back-to-back accesses.
- Grant timing:
  - gnt_i is combinational from req_0/req_1/lock_i and registered state. Zero-cycle grant when uncontested.
  - At most one gnt per cycle.
- Memory port:
  - mem_en = gnt_0|gnt_1.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - rvalid_i <= gnt_i & ~we_i.
  - rdata_i is captured from mem_rdata in the cycle rvalid_i is high and holds until the next read return.
  - Fixed latency: exactly 1 cycle after the grant. Writes produce no response.
- Arbitration, locked=1:
  - Only the owner may be granted; the other requester waits regardless of hold_cnt.
  - locked clears when the owner is granted with lock=0, or when the owner's req is low for a cycle.
  - Clearing takes effect the next cycle.
- Arbitration, locked=0:
  - Only one req: grant it.
  - Both req and owner's hold_cnt < MAX_HOLD: grant the owner.
  - Both req and hold_cnt >= MAX_HOLD: grant the non-owner.
  - Neither: no grant, state holds.
- Locking: a grant with lock_i=1 sets locked=1 and owner=i.
- State update on grant to i:
  - If i==owner: hold_cnt saturating increment (4-bit).
  - Else: owner<=i, hold_cnt<=1.
- hold_cnt is not reset by idle cycles. Fairness is counted over consecutive contended grants only.
- Boundaries:
  - Same-address read and write in consecutive cycles from different requesters: the read returns the value in memory at its issue cycle (memory semantics). The arbiter does no forwarding.
  - Reset during an outstanding read: rvalid is dropped and the read is never returned.
  - Reset while locked: the lock is released.
  - A requester deasserting req_i without a grant is legal; its request is withdrawn.
  - Changing lock_i while ungranted has no effect.

Test Plan:
- Reset then idle, req_0 read addr 0x10 (mem holds 0x5A) -> gnt_0=1 same cycle, mem_en=1, mem_addr=0x10, next cycle rvalid_0=1, rdata_0=0x5A; gnt_1/rvalid_1 stay 0.
- Both requesters hold req continuously (reads), MAX_HOLD=4, from reset -> grant sequence 0,0,0,0,1,1,1,1,0,... ; no cycle has both gnts; every grant followed by exactly one rvalid on the matching port.
- req_1 write addr 0xA0 data 0x3C in the same cycle as req_0 read of 0xA0 (owner=1 by prior grant) -> cycle N gnt_1, mem_we=1; cycle N+1 gnt_0 read; cycle N+2 rvalid_0, rdata_0=0x3C.
- req_0 with lock_0=1 granted, then req_0 held with lock_0=1 for 6 cycles while req_1 is high -> 7 consecutive gnt_0 (MAX_HOLD ignored), locked=1; next req_0 with lock_0=0 granted -> locked=0 the following cycle, then gnt_1.
- Read granted to requester 1 in cycle N, rst=1 in cycle N+1 -> rvalid_1=0 in N+1 and N+2, locked=0, owner=0; after release both requesting -> first grant to requester 0.
- Owner 0 locked, req_0 dropped for one cycle with req_1 high -> no grant that cycle, locked=0 next cycle, gnt_1 issued the next cycle.
